// File: rtl/taxi_axil_if.sv
// AXI4-Lite bus bundle with separate write and read master/slave views.
// Latency: none, wires only.
// Backpressure: standard AXI valid/ready on each of the five channels.
interface taxi_axil_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int STRB_W = DATA_W / 8,
  parameter int USER_W = 1
) ();
  // write address channel
  logic [ADDR_W-1:0] awaddr;
  logic [2:0]        awprot;
  logic [USER_W-1:0] awuser;
  logic              awvalid;
  logic              awready;
  // write data channel
  logic [DATA_W-1:0] wdata;
  logic [STRB_W-1:0] wstrb;
  logic [USER_W-1:0] wuser;
  logic              wvalid;
  logic              wready;
  // write response channel
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;
  // read address channel
  logic [ADDR_W-1:0] araddr;
  logic [2:0]        arprot;
  logic [USER_W-1:0] aruser;
  logic              arvalid;
  logic              arready;
  // read data channel
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready;

  modport wr_mst (
    output awaddr, awprot, awuser, awvalid, input awready,
    output wdata, wstrb, wuser, wvalid, input wready,
    input bresp, bvalid, output bready
  );

  modport wr_slv (
    input awaddr, awprot, awuser, awvalid, output awready,
    input wdata, wstrb, wuser, wvalid, output wready,
    output bresp, bvalid, input bready
  );

  modport rd_mst (
    output araddr, arprot, aruser, arvalid, input arready,
    input rdata, rresp, rvalid, output rready
  );

  modport rd_slv (
    input araddr, arprot, aruser, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );
endinterface

// File: rtl/taxi_axil_req_arb.sv
// Round-robin arbiter sharing one AXI4-Lite master among PORTS single-beat requesters.
// Latency: grant in request cycle, address beat +1, response pulse +3 minimum (zero-wait slave).
// Backpressure: one transaction in flight; others wait on req_ready, responses have no backpressure.
module taxi_axil_req_arb #(
  parameter int PORTS  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int STRB_W = DATA_W / 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [PORTS-1:0]         req_valid,
  output logic [PORTS-1:0]         req_ready,
  input  logic [PORTS-1:0]         req_we,
  input  logic [PORTS*ADDR_W-1:0]  req_addr,
  input  logic [PORTS*DATA_W-1:0]  req_wdata,
  input  logic [PORTS*STRB_W-1:0]  req_wstrb,
  output logic [PORTS-1:0]         rsp_valid,
  output logic [DATA_W-1:0]        rsp_rdata,
  output logic [1:0]               rsp_resp,
  taxi_axil_if.wr_mst              m_axil_wr,
  taxi_axil_if.rd_mst              m_axil_rd
);
  localparam int PW = (PORTS > 1) ? $clog2(PORTS) : 1;

  typedef enum logic [2:0] {
    IDLE,
    WR_ADDR,
    WR_RESP,
    RD_ADDR,
    RD_RESP
  } state_t;

  state_t            state;
  logic [PW-1:0]     ptr;
  logic [PW-1:0]     gnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [STRB_W-1:0] wstrb_q;
  logic              awvalid_q;
  logic              wvalid_q;
  logic              bready_q;
  logic              arvalid_q;
  logic              rready_q;

  logic              grant_vld;
  logic [PW-1:0]     grant_idx;
  logic [PW-1:0]     ptr_next;
  logic              aw_done;
  logic              w_done;

  // first pending request at or above ptr, wrapping around
  always_comb begin
    int j;
    j         = 0;
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int i = 0; i < PORTS; i++) begin
      j = int'(ptr) + i;
      if (j >= PORTS) j = j - PORTS;
      if (!grant_vld && req_valid[j]) begin
        grant_vld = 1'b1;
        grant_idx = PW'(j);
      end
    end
  end

  assign ptr_next = (grant_idx == PW'(PORTS - 1)) ? '0 : grant_idx + 1'b1;

  // gated by rst_n so a requester held high during reset never sees an acceptance
  assign req_ready = (rst_n && state == IDLE && grant_vld) ? (PORTS'(1) << grant_idx) : '0;

  // a channel counts as done once its valid has dropped or is handshaking now
  assign aw_done = !awvalid_q || m_axil_wr.awready;
  assign w_done  = !wvalid_q  || m_axil_wr.wready;

  assign m_axil_wr.awaddr  = addr_q;
  assign m_axil_wr.awprot  = 3'b000;
  assign m_axil_wr.awuser  = '0;
  assign m_axil_wr.awvalid = awvalid_q;
  assign m_axil_wr.wdata   = wdata_q;
  assign m_axil_wr.wstrb   = wstrb_q;
  assign m_axil_wr.wuser   = '0;
  assign m_axil_wr.wvalid  = wvalid_q;
  assign m_axil_wr.bready  = bready_q;
  assign m_axil_rd.araddr  = addr_q;
  assign m_axil_rd.arprot  = 3'b000;
  assign m_axil_rd.aruser  = '0;
  assign m_axil_rd.arvalid = arvalid_q;
  assign m_axil_rd.rready  = rready_q;

  // transaction sequencer: latch grant, drive AXI channels, pulse the response back
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      gnt_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      rsp_valid <= '0;
      rsp_rdata <= '0;
      rsp_resp  <= '0;
    end else begin
      rsp_valid <= '0;
      case (state)
        IDLE: begin
          if (grant_vld) begin
            gnt_q   <= grant_idx;
            addr_q  <= req_addr[grant_idx*ADDR_W +: ADDR_W];
            wdata_q <= req_wdata[grant_idx*DATA_W +: DATA_W];
            wstrb_q <= req_wstrb[grant_idx*STRB_W +: STRB_W];
            ptr     <= ptr_next;
            if (req_we[grant_idx]) begin
              state     <= WR_ADDR;
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
            end else begin
              state     <= RD_ADDR;
              arvalid_q <= 1'b1;
            end
          end
        end
        WR_ADDR: begin
          if (m_axil_wr.awready) awvalid_q <= 1'b0;
          if (m_axil_wr.wready)  wvalid_q  <= 1'b0;
          if (aw_done && w_done) begin
            state    <= WR_RESP;
            bready_q <= 1'b1;
          end
        end
        WR_RESP: begin
          if (m_axil_wr.bvalid) begin
            bready_q  <= 1'b0;
            rsp_resp  <= m_axil_wr.bresp;
            rsp_rdata <= '0;
            rsp_valid <= PORTS'(1) << gnt_q;
            state     <= IDLE;
          end
        end
        RD_ADDR: begin
          if (m_axil_rd.arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state     <= RD_RESP;
          end
        end
        RD_RESP: begin
          if (m_axil_rd.rvalid) begin
            rready_q  <= 1'b0;
            rsp_resp  <= m_axil_rd.rresp;
            rsp_rdata <= m_axil_rd.rdata;
            rsp_valid <= PORTS'(1) << gnt_q;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_taxi_axil_req_arb.sv
// Bench for taxi_axil_req_arb: arbitration model plus response scoreboard against a configurable slave.
// Latency: expected response cycle derived from the slave delay settings.
// Backpressure: slave readies/valids delayed per test to exercise stalls.
module tb_taxi_axil_req_arb;
  localparam int PORTS = 4;

  typedef struct {
    int          port;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] rdata;
    logic [1:0]  resp;
    int          lat;
    int          t_acc;
  } exp_t;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [PORTS-1:0]     req_valid, req_ready, req_we, rsp_valid;
  logic [PORTS*32-1:0]  req_addr, req_wdata;
  logic [PORTS*4-1:0]   req_wstrb;
  logic [31:0]          rsp_rdata;
  logic [1:0]           rsp_resp;

  taxi_axil_if #(.ADDR_W(32), .DATA_W(32)) axil ();

  taxi_axil_req_arb #(.PORTS(PORTS), .ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .m_axil_wr(axil), .m_axil_rd(axil)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // slave delay and response settings
  int          aw_delay = 0, w_delay = 0, b_delay = 0, ar_delay = 0, r_delay = 0;
  logic [1:0]  bresp_k = 2'd0, rresp_k = 2'd0;
  logic [31:0] rdata_k = 32'h0;

  int   aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
  logic aw_seen, w_seen, b_wait, r_wait;

  assign axil.awready = axil.awvalid && (aw_cnt >= aw_delay);
  assign axil.wready  = axil.wvalid  && (w_cnt  >= w_delay);
  assign axil.arready = axil.arvalid && (ar_cnt >= ar_delay);
  assign axil.bvalid  = b_wait && (b_cnt >= b_delay);
  assign axil.bresp   = bresp_k;
  assign axil.rvalid  = r_wait && (r_cnt >= r_delay);
  assign axil.rdata   = axil.rvalid ? rdata_k : 32'h0;
  assign axil.rresp   = rresp_k;

  // slave: delayed readies, response issued once address (and data) accepted
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0; b_cnt <= 0; r_cnt <= 0;
      aw_seen <= 1'b0; w_seen <= 1'b0; b_wait <= 1'b0; r_wait <= 1'b0;
    end else begin
      aw_cnt <= (axil.awvalid && !axil.awready) ? aw_cnt + 1 : 0;
      w_cnt  <= (axil.wvalid  && !axil.wready)  ? w_cnt + 1  : 0;
      ar_cnt <= (axil.arvalid && !axil.arready) ? ar_cnt + 1 : 0;
      if ((aw_seen || (axil.awvalid && axil.awready)) && (w_seen || (axil.wvalid && axil.wready))) begin
        aw_seen <= 1'b0; w_seen <= 1'b0; b_wait <= 1'b1; b_cnt <= 0;
      end else begin
        if (axil.awvalid && axil.awready) aw_seen <= 1'b1;
        if (axil.wvalid && axil.wready)   w_seen  <= 1'b1;
      end
      if (axil.bvalid && axil.bready) b_wait <= 1'b0;
      else if (b_wait && !axil.bvalid) b_cnt <= b_cnt + 1;
      if (axil.arvalid && axil.arready) begin
        r_wait <= 1'b1; r_cnt <= 0;
      end
      if (axil.rvalid && axil.rready) r_wait <= 1'b0;
      else if (r_wait && !axil.rvalid) r_cnt <= r_cnt + 1;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // monitor / model state
  exp_t             sb[$];
  exp_t             e;
  int               grant_q[$], acc_cyc_q[$], rsp_cyc_q[$];
  int               mptr = 0, g, rsp_count = 0;
  bit               mbusy = 0;
  int               aw_cyc, w_cyc, b_cyc;
  logic [PORTS-1:0] acc_mask = '0, hold_mask = '0, exp_rdy;

  // monitor: check handshakes and responses, predict arbitration, push expectations
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete(); mptr = 0; mbusy = 0; acc_mask = '0;
      check("rst_req_ready", 64'(req_ready), 64'd0);
      check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    end else begin
      if (axil.awvalid) aw_cyc++;
      if (axil.wvalid)  w_cyc++;
      if (axil.bready)  b_cyc++;
      if (axil.awvalid && axil.awready) begin
        if (sb.size() == 0) check("aw_orphan", 64'd1, 64'd0);
        else begin
          check("awaddr", 64'(axil.awaddr), 64'(sb[0].addr));
          check("awprot", 64'(axil.awprot), 64'd0);
        end
      end
      if (axil.wvalid && axil.wready) begin
        if (sb.size() == 0) check("w_orphan", 64'd1, 64'd0);
        else begin
          check("wdata", 64'(axil.wdata), 64'(sb[0].wdata));
          check("wstrb", 64'(axil.wstrb), 64'(sb[0].wstrb));
        end
      end
      if (axil.arvalid && axil.arready) begin
        if (sb.size() == 0) check("ar_orphan", 64'd1, 64'd0);
        else check("araddr", 64'(axil.araddr), 64'(sb[0].addr));
      end
      if (rsp_valid != '0) begin
        if (sb.size() == 0) check("rsp_orphan", 64'(rsp_valid), 64'd0);
        else begin
          e = sb.pop_front();
          check("rsp_port", 64'(rsp_valid), 64'(4'b0001 << e.port));
          check("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
          check("rsp_resp", 64'(rsp_resp), 64'(e.resp));
          check("rsp_latency", 64'(cyc - e.t_acc), 64'(e.lat));
          if (e.we) begin
            check("aw_valid_cycles", 64'(aw_cyc), 64'(aw_delay + 1));
            check("w_valid_cycles", 64'(w_cyc), 64'(w_delay + 1));
            check("b_wait_cycles", 64'(b_cyc), 64'(b_delay + 1));
          end
        end
        rsp_cyc_q.push_back(cyc);
        rsp_count++;
        mbusy = 0;
      end
      g = -1;
      if (!mbusy) begin
        for (int i = 0; i < PORTS; i++) begin
          int j;
          j = (mptr + i) % PORTS;
          if (g < 0 && req_valid[j]) g = j;
        end
      end
      exp_rdy = (g >= 0) ? (4'b0001 << g) : 4'b0000;
      check("req_ready", 64'(req_ready), 64'(exp_rdy));
      if (g >= 0) begin
        e.port  = g;
        e.we    = req_we[g];
        e.addr  = req_addr[g*32 +: 32];
        e.wdata = req_wdata[g*32 +: 32];
        e.wstrb = req_wstrb[g*4 +: 4];
        e.rdata = e.we ? 32'h0 : rdata_k;
        e.resp  = e.we ? bresp_k : rresp_k;
        e.lat   = e.we ? 3 + ((aw_delay > w_delay) ? aw_delay : w_delay) + b_delay : 3 + ar_delay + r_delay;
        e.t_acc = cyc;
        sb.push_back(e);
        grant_q.push_back(g);
        acc_cyc_q.push_back(cyc);
        mptr  = (g + 1) % PORTS;
        mbusy = 1;
        aw_cyc = 0; w_cyc = 0; b_cyc = 0;
      end
      acc_mask = req_ready;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    req_valid = req_valid & ~(acc_mask & ~hold_mask);
  endtask

  task automatic issue(input int p, input logic we, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    req_we[p]          = we;
    req_addr[p*32 +: 32]  = a;
    req_wdata[p*32 +: 32] = d;
    req_wstrb[p*4 +: 4]   = s;
    req_valid[p]       = 1'b1;
  endtask

  task automatic wait_done(input string tag, input int max);
    int n;
    n = 0;
    while ((req_valid != '0 || sb.size() != 0) && n < max) begin
      step();
      n++;
    end
    if (n >= max) check({tag, "_timeout"}, 64'd1, 64'd0);
  endtask

  int k, r, n;

  initial begin
    rst_n = 1'b0; req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
    #1;
    check("rst_awvalid", 64'(axil.awvalid), 64'd0);
    check("rst_wvalid", 64'(axil.wvalid), 64'd0);
    check("rst_arvalid", 64'(axil.arvalid), 64'd0);
    check("rst_bready", 64'(axil.bready), 64'd0);
    check("rst_rready", 64'(axil.rready), 64'd0);
    check("rst_awaddr", 64'(axil.awaddr), 64'd0);
    repeat (3) step();
    rst_n = 1'b1;
    step();

    // fairness: all ports hold requests; grants must rotate 0,1,2,3,0,1
    k = grant_q.size();
    r = rsp_count;
    hold_mask = 4'hF;
    for (int p = 0; p < PORTS; p++)
      issue(p, (p % 2) == 0, 32'h100 * p + 32'h40, 32'hA000_0000 | p, 4'(p + 1));
    rdata_k = 32'hCAFE_0001;
    n = 0;
    while (rsp_count < r + 6 && n < 100) begin step(); n++; end
    if (n >= 100) check("fair_timeout", 64'd1, 64'd0);
    hold_mask = '0;
    req_valid = '0;
    wait_done("fair_drain", 50);
    for (int i = 0; i < 6; i++)
      if (k + i < grant_q.size()) check("fair_order", 64'(grant_q[k + i]), 64'(i % PORTS));
      else check("fair_missing", 64'd1, 64'd0);

    // single write from port 2, zero-wait slave
    bresp_k = 2'd0;
    issue(2, 1'b1, 32'h1000, 32'hDEAD_BEEF, 4'hF);
    wait_done("wr", 50);

    // single read from port 0 with SLVERR
    rdata_k = 32'h1234_5678; rresp_k = 2'd2;
    issue(0, 1'b0, 32'h20, 32'h0, 4'h0);
    wait_done("rd", 50);
    rresp_k = 2'd0;

    // split write handshake: awready late, wready immediate, one B wait
    aw_delay = 2; w_delay = 0; b_delay = 1; bresp_k = 2'd1;
    issue(3, 1'b1, 32'h3000, 32'h5555_AAAA, 4'h3);
    wait_done("split", 50);
    aw_delay = 0; b_delay = 0; bresp_k = 2'd0;

    // slave stalls B for 10 cycles while port 1 waits
    b_delay = 10;
    k = grant_q.size();
    r = rsp_cyc_q.size();
    issue(0, 1'b1, 32'h2000, 32'h0BAD_F00D, 4'hF);
    step(); step();
    rdata_k = 32'h7777_0000;
    issue(1, 1'b0, 32'h2004, 32'h0, 4'h0);
    wait_done("stall", 100);
    b_delay = 0;
    if (grant_q.size() >= k + 2 && rsp_cyc_q.size() >= r + 1) begin
      check("stall_first", 64'(grant_q[k]), 64'd0);
      check("stall_second", 64'(grant_q[k + 1]), 64'd1);
      check("stall_grant_cycle", 64'(acc_cyc_q[k + 1]), 64'(rsp_cyc_q[r]));
    end else check("stall_missing", 64'd1, 64'd0);

    // reset during RD_RESP, then ptr must be back at 0
    r_delay = 20;
    issue(2, 1'b0, 32'h40, 32'h0, 4'h0);
    n = 0;
    while (!axil.rready && n < 20) begin step(); n++; end
    check("rd_resp_reached", 64'(axil.rready), 64'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_rready", 64'(axil.rready), 64'd0);
    check("mid_rst_arvalid", 64'(axil.arvalid), 64'd0);
    check("mid_rst_araddr", 64'(axil.araddr), 64'd0);
    check("mid_rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("mid_rst_req_ready", 64'(req_ready), 64'd0);
    req_valid = '0;
    r_delay = 0;
    repeat (3) step();
    rst_n = 1'b1;
    step();
    k = grant_q.size();
    rdata_k = 32'h0000_BEEF;
    issue(3, 1'b0, 32'h300, 32'h0, 4'h0);
    issue(0, 1'b0, 32'h000, 32'h0, 4'h0);
    wait_done("post_rst", 50);
    if (grant_q.size() >= k + 2) begin
      check("post_rst_first", 64'(grant_q[k]), 64'd0);
      check("post_rst_second", 64'(grant_q[k + 1]), 64'd3);
    end else check("post_rst_missing", 64'd1, 64'd0);

    repeat (3) step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
